// File: rtl/xadc_drp_sequencer_if.sv
// xadc_drp_sequencer_if
// DRP bus between the sequencer and the xadc_wiz_0 instance.
//   drp_den    enable pulse, one cycle per read
//   drp_daddr  register address, held from den until drdy
//   drp_dwe    write enable (the sequencer only reads, drives 0)
//   drp_drdy   read data ready
//   drp_do     read data
// master: sequencer side. slave: XADC side.
interface xadc_drp_sequencer_if;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_dwe;
  logic        drp_drdy;
  logic [15:0] drp_do;

  modport master (output drp_den, drp_daddr, drp_dwe, input drp_drdy, drp_do);
  modport slave  (input drp_den, drp_daddr, drp_dwe, output drp_drdy, drp_do);
endinterface

// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer
// On each trigger, reads every enabled channel slot of the XADC over DRP in
// ascending slot order, one read at a time, and keeps the latest result per slot.
// Ports:
//   clk, reset    clock (also XADC dclk), synchronous active-high reset
//   trigger       start one round (usually eoc_out); pulse or level
//   ch_addr       DRP address per slot, slot i = [7i+6:7i]
//   ch_enable     per-slot enable mask, latched at round start
//   drp           DRP bus (master modport)
//   result_data   last result per slot, slot i = [16i+15:16i]
//   result_valid  one-cycle pulse, slot result_ch was just updated
//   result_ch     slot index of the update
//   round_done    one-cycle pulse with the last slot of a round
//   busy          high whenever the FSM is not idle
//   overrun       sticky, trigger seen while busy
//   timeout_err   sticky, a read timed out
// Optional feature: define XADC_SEQ_TIMEOUT_EN to bound the wait for drdy to
// TIMEOUT_CYC cycles; otherwise WAIT waits forever and timeout_err is 0.
module xadc_drp_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [NUM_CH*7-1:0]    ch_addr,
  input  logic [NUM_CH-1:0]      ch_enable,
  xadc_drp_sequencer_if.master   drp,
  output logic [NUM_CH*16-1:0]   result_data,
  output logic                   result_valid,
  output logic [2:0]             result_ch,
  output logic                   round_done,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [1:0]        state;
  logic [NUM_CH-1:0] mask_q;
  logic [2:0]        ptr;
  logic [2:0]        first_idx;
  logic [2:0]        next_idx;
  logic              has_next;
  logic              to_hit;

  // Lowest enabled slot of the live mask, and the next enabled slot above
  // ptr in the latched mask. Descending scan leaves the lowest match.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) first_idx = 3'(i);
      if (mask_q[i] && (i > int'(ptr))) begin
        next_idx = 3'(i);
        has_next = 1'b1;
      end
    end
  end

`ifdef XADC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;

  // wait_cnt is 0 on the first WAIT cycle; expiry on the TIMEOUT_CYC-th WAIT
  // cycle unless drdy arrives in that same cycle.
  always_ff @(posedge clk) begin
    if (reset)               wait_cnt <= '0;
    else if (state != S_WAIT) wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + CW'(1);
  end

  assign to_hit = (state == S_WAIT) && !drp.drp_drdy &&
                  (wait_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset)       timeout_err <= 1'b0;
    else if (to_hit) timeout_err <= 1'b1;
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign drp.drp_dwe = 1'b0;

  // Outputs are registered on the same edge as the state change, so den is
  // high exactly while in ISSUE and result_valid/round_done exactly in STORE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      mask_q        <= '0;
      ptr           <= '0;
      drp.drp_den   <= 1'b0;
      drp.drp_daddr <= '0;
      result_data   <= '0;
      result_valid  <= 1'b0;
      result_ch     <= '0;
      round_done    <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      drp.drp_den  <= 1'b0;
      result_valid <= 1'b0;
      round_done   <= 1'b0;
      // Includes the STORE->IDLE cycle: such a trigger is dropped too.
      if (trigger && (state != S_IDLE)) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trigger && (|ch_enable)) begin
            mask_q        <= ch_enable;
            ptr           <= first_idx;
            drp.drp_den   <= 1'b1;
            drp.drp_daddr <= ch_addr[7*first_idx +: 7];
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (drp.drp_drdy || to_hit) begin
            round_done <= !has_next;
            state      <= S_STORE;
            if (drp.drp_drdy) begin
              result_data[16*ptr +: 16] <= drp.drp_do;
              result_valid              <= 1'b1;
              result_ch                 <= ptr;
            end
          end
        end
        default: begin // S_STORE
          if (has_next) begin
            ptr           <= next_idx;
            drp.drp_den   <= 1'b1;
            drp.drp_daddr <= ch_addr[7*next_idx +: 7];
            state         <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
module tb_xadc_drp_sequencer;
  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [27:0] ch_addr;
  logic [3:0]  ch_enable;
  logic [63:0] result_data;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic        round_done;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  xadc_drp_sequencer_if drp();

  xadc_drp_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .ch_addr(ch_addr),
    .ch_enable(ch_enable), .drp(drp), .result_data(result_data),
    .result_valid(result_valid), .result_ch(result_ch), .round_done(round_done),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] data;
    logic        done;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  int          den_cnt = 0;
  logic [6:0]  exp_addr_q[$];
  res_t        exp_res_q[$];

  // DRP model controls
  logic        model_on = 1'b0;
  int          model_delay = 3;
  logic [6:0]  hold_addr = 7'h7F;
  logic [15:0] data_base = 16'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // DRP slave model: drdy model_delay cycles after den, data = base + addr.
  always begin
    logic [6:0] a;
    @(negedge clk);
    if (drp.drp_den && model_on) begin
      a = drp.drp_daddr;
      if (a != hold_addr) begin
        repeat (model_delay) @(posedge clk);
        #1;
        drp.drp_drdy = 1'b1;
        drp.drp_do   = data_base + {9'b0, a};
        @(posedge clk);
        #1;
        drp.drp_drdy = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [6:0] a;
    res_t r;
    if (drp.drp_den) begin
      den_cnt++;
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL den_unexpected daddr=%0h required=no_den", drp.drp_daddr);
      end else begin
        a = exp_addr_q.pop_front();
        chk("den_daddr", 64'(drp.drp_daddr), 64'(a));
      end
    end
    if (result_valid) begin
      if (exp_res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL result_unexpected ch=%0d required=no_result", result_ch);
      end else begin
        r = exp_res_q.pop_front();
        chk("result_ch", 64'(result_ch), 64'(r.ch));
        chk("result_data", 64'(result_data[16*r.ch +: 16]), 64'(r.data));
        chk("round_done", 64'(round_done), 64'(r.done));
      end
    end else if (round_done) begin
      checks++; errors++;
      $display("FAIL round_done_alone actual=1 required=0");
    end
  end

  task automatic push_res(input logic [2:0] ch, input logic [15:0] data, input logic done);
    res_t r;
    r.ch = ch; r.data = data; r.done = done;
    exp_res_q.push_back(r);
  endtask

  // Expected den addresses / results for a full round with a responsive model.
  task automatic expect_round(input logic [3:0] mask, input logic [27:0] addrs,
                              input logic [15:0] base);
    int last;
    logic [6:0] a;
    last = -1;
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) last = i;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        a = addrs[7*i +: 7];
        exp_addr_q.push_back(a);
        push_res(3'(i), base + {9'b0, a}, i == last);
      end
    end
  endtask

  task automatic start(input logic [3:0] mask, input logic [27:0] addrs);
    @(posedge clk); #1;
    ch_enable = mask; ch_addr = addrs; trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_in_budget"}, 64'(busy), 64'(0));
    chk({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'(0));
    chk({name, "_res_q_empty"}, 64'(exp_res_q.size()), 64'(0));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_result_data"}, result_data, 64'(0));
    chk({name, "_result_valid"}, 64'(result_valid), 64'(0));
    chk({name, "_result_ch"}, 64'(result_ch), 64'(0));
    chk({name, "_round_done"}, 64'(round_done), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_overrun"}, 64'(overrun), 64'(0));
    chk({name, "_timeout_err"}, 64'(timeout_err), 64'(0));
    chk({name, "_den"}, 64'(drp.drp_den), 64'(0));
    chk({name, "_daddr"}, 64'(drp.drp_daddr), 64'(0));
    chk({name, "_dwe"}, 64'(drp.drp_dwe), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; trigger = 1'b0; ch_addr = '0; ch_enable = '0;
    drp.drp_drdy = 1'b0; drp.drp_do = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Round over slots 0,1,3; addresses slot3..0 = 1C,1F,1E,1D.
    model_on = 1'b1; model_delay = 3; data_base = 16'h1000;
    exp_addr_q.push_back(7'h1D);
    exp_addr_q.push_back(7'h1E);
    exp_addr_q.push_back(7'h1C);
    push_res(3'd0, 16'h101D, 1'b0);
    push_res(3'd1, 16'h101E, 1'b0);
    push_res(3'd3, 16'h101C, 1'b1);
    start(4'b1011, {7'h1C, 7'h1F, 7'h1E, 7'h1D});
    @(negedge clk);
    chk("t1_den_at_t+1", 64'(drp.drp_den), 64'(1));
    chk("t1_daddr_at_t+1", 64'(drp.drp_daddr), 64'(7'h1D));
    chk("t1_busy", 64'(busy), 64'(1));
    wait_idle("t1");
    chk("t1_overrun", 64'(overrun), 64'(0));
    chk("t1_slot2_untouched", 64'(result_data[47:32]), 64'(0));
    chk("t1_slot3", 64'(result_data[63:48]), 64'(16'h101C));

    // Empty mask: trigger ignored.
    start(4'b0000, {7'h1C, 7'h1F, 7'h1E, 7'h1D});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("m0_busy", 64'(busy), 64'(0));
      chk("m0_den", 64'(drp.drp_den), 64'(0));
      chk("m0_round_done", 64'(round_done), 64'(0));
    end

    // Second trigger two cycles after the first: dropped, overrun set.
    data_base = 16'h2000;
    den_cnt = 0;
    expect_round(4'b1111, {7'h23, 7'h22, 7'h21, 7'h20}, 16'h2000);
    @(posedge clk); #1;
    ch_enable = 4'b1111; ch_addr = {7'h23, 7'h22, 7'h21, 7'h20}; trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    @(negedge clk);
    chk("ovr_overrun", 64'(overrun), 64'(1));
    wait_idle("ovr");
    repeat (10) @(negedge clk);
    chk("ovr_still_idle", 64'(busy), 64'(0));
    chk("ovr_den_count", 64'(den_cnt), 64'(NUM_CH));

    // Mask shrinks mid-round: latched mask still drives the round.
    data_base = 16'h3000;
    den_cnt = 0;
    expect_round(4'b1111, {7'h33, 7'h32, 7'h31, 7'h30}, 16'h3000);
    start(4'b1111, {7'h33, 7'h32, 7'h31, 7'h30});
    @(posedge clk); #1 ch_enable = 4'b0001;
    wait_idle("mchg");
    chk("mchg_den_count", 64'(den_cnt), 64'(NUM_CH));
    chk("mchg_slot3", 64'(result_data[63:48]), 64'(16'h3033));

`ifdef XADC_SEQ_TIMEOUT_EN
    // drdy exactly on the expiry cycle: normal store.
    data_base = 16'h4000; model_delay = 8;
    expect_round(4'b0111, {7'h13, 7'h12, 7'h11, 7'h10}, 16'h4000);
    start(4'b0111, {7'h13, 7'h12, 7'h11, 7'h10});
    wait_idle("exp");
    chk("exp_timeout_err", 64'(timeout_err), 64'(0));
    chk("exp_slot1", 64'(result_data[31:16]), 64'(16'h4011));

    // Slot 1 never answers: timeout, old value kept, slot 2 still read.
    data_base = 16'h5000; model_delay = 3; hold_addr = 7'h11;
    exp_addr_q.push_back(7'h10);
    exp_addr_q.push_back(7'h11);
    exp_addr_q.push_back(7'h12);
    push_res(3'd0, 16'h5010, 1'b0);
    push_res(3'd2, 16'h5012, 1'b1);
    start(4'b0111, {7'h13, 7'h12, 7'h11, 7'h10});
    wait_idle("to");
    hold_addr = 7'h7F;
    chk("to_timeout_err", 64'(timeout_err), 64'(1));
    chk("to_slot1_kept", 64'(result_data[31:16]), 64'(16'h4011));
    chk("to_slot2", 64'(result_data[47:32]), 64'(16'h5012));
`endif

    // Reset while waiting for drdy, then a late drdy.
    model_on = 1'b0;
    exp_addr_q.push_back(7'h40);
    start(4'b0001, {7'h43, 7'h42, 7'h41, 7'h40});
    @(negedge clk);
    chk("rst_busy_in_wait", 64'(busy), 64'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    drp.drp_drdy = 1'b1; drp.drp_do = 16'hBEEF;
    @(posedge clk); #1 drp.drp_drdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_late_valid", 64'(result_valid), 64'(0));
      chk("rst_late_busy", 64'(busy), 64'(0));
    end
    chk("rst_late_data", result_data, 64'(0));
    chk("end_addr_q_empty", 64'(exp_addr_q.size()), 64'(0));
    chk("end_res_q_empty", 64'(exp_res_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
